conv_relu_pool_engine: RTL
==========================

Name: conv_relu_pool_engine

Overview:
- Parametrised successor streaming CNN stage: runtime-sized image, NUM_CH parallel 3x3 kernels, requantisation, optional ReLU, true 2x2/stride-2 max pooling.
- Ready/valid on both sides, so it sits between an OBI DMA reader and writer in the accelerator subsystem.
- The register-file wrapper drives cfg_* and start; this block has no bus logic.

Parameters:
DATA_WIDTH, 8, input pixel width (unsigned)
W_WIDTH, 8, weight width (signed)
ACC_WIDTH, 32, accumulator width (signed)
OUT_WIDTH, 8, output lane width (signed, saturated)
IMG_W_MAX, 64, maximum image width; sets line-buffer depth
NUM_CH, 2, output channels (kernels)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse; sampled only in IDLE
cfg_width_i  in  $clog2(IMG_W_MAX+1)  image width W
cfg_height_i  in  16  image height H
cfg_shift_i  in  5  arithmetic right shift applied to accumulator
cfg_relu_en_i  in  1  ReLU enable
cfg_pool_en_i  in  1  2x2 max-pool enable
weights_i  in  NUM_CH*9*W_WIDTH  kernel k, tap t (row-major) at bits [(k*9+t)*W_WIDTH +: W_WIDTH]
in_data_i  in  DATA_WIDTH  pixel, raster order
in_valid_i  in  1  pixel valid
in_ready_o  out  1  pixel accepted when valid&&ready
out_data_o  out  NUM_CH*OUT_WIDTH  channel k in lane k
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
out_last_o  out  1  marks the final result of the frame
busy_o  out  1  high in RUN and FLUSH
done_o  out  1  one-cycle pulse when a frame completes
err_o  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (rst_i high at a clock edge, any state):
  - State goes to IDLE; pixel counters, line buffers and pool row buffer are cleared.
  - All outputs are 0.
  - An in-flight frame is abandoned; no done_o.
- FSM: IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE: start_i with 3<=W<=IMG_W_MAX and H>=3 latches all cfg_* and weights_i, then goes to RUN. cfg_* and weights_i are ignored afterwards.
  - IDLE, invalid config on start_i: err_o pulses the next cycle; state stays IDLE.
  - start_i outside IDLE is ignored.
  - RUN: accepts W*H pixels. After the last pixel is accepted, go to FLUSH.
  - FLUSH: wait until out_valid_o is low, or the last result handshakes. Then pulse done_o for one cycle and return to IDLE.
- Stall rule: advance = !out_valid_o || out_ready_i. in_ready_o = (state==RUN) && advance. No skid buffer. out_data_o, out_valid_o and out_last_o are held stable while stalled.
- Window formation:
  - Two line buffers of IMG_W_MAX entries each, indexed by column and written on accept. Only the first W entries are used.
  - Three-tap shift registers per row.
  - When the accepted pixel sits at (r,c) with r>=2 and c>=2, it completes a window covering rows r-2..r and cols c-2..c. No padding.
  - Windows must not wrap across row boundaries.
- Arithmetic, per channel:
  - acc = sum over 9 taps of zero-extended pixel × signed weight, computed at ACC_WIDTH.
  - v = acc >>> cfg_shift.
  - If relu_en and v<0, v = 0.
  - Saturate v to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- No pool:
  - The result for conv position (r-2,c-2) is registered on the accepting edge, so it is valid the next cycle (latency 1).
  - Frame produces (W-2)*(H-2) results.
- Pool enabled (conv map coordinates i=r-2, j=c-2):
  - Pairs (j even, j+1) are reduced to a horizontal max.
  - On even i, the pair max is stored in a row buffer of IMG_W_MAX/2 entries × NUM_CH lanes.
  - On odd i, the stored value is maxed with the new pair max and emitted with latency 1 from the accept of pixel (r, c) with j odd.
  - Odd trailing conv column or row is dropped (floor).
  - Frame produces floor((W-2)/2)*floor((H-2)/2) results.
  - Pooling operates on saturated, ReLU'd values, per lane.
- out_last_o is high with the final result only.
- in_ready_o stays low outside RUN.

Test Plan:
- W=4, H=4, pixels 1..16, ch0 weights all +1, ch1 centre tap +1 only, shift=0, relu off, pool off:
  - ch0 outputs 54, 63, 90, 99; ch1 outputs 6, 7, 10, 11.
  - out_last_o on the 4th result; done_o one cycle after its handshake.
- Same stimulus with pool on: single result, ch0=99, ch1=11, out_last_o=1.
- ch0 weights all -1:
  - relu off: -54 saturates to -54 (in range), then -63, -90, -99 (within int8).
  - relu on: all four results are 0.
- All pixels 255, weights +1, shift=4: acc=2295, 2295>>>4 = 143, saturated to 127.
- Backpressure: hold out_ready_i low for 5 cycles mid-frame.
  - in_ready_o stays low throughout; out_data_o is stable.
  - No result is lost or duplicated; result sequence is identical to the unstalled run.
- start_i with W=2:
  - err_o pulses and busy_o stays 0.
  - Then a valid start is issued and rst_i is asserted after 7 pixels: all outputs return to 0 and done_o never pulses.
  - A fresh frame afterwards produces the correct results.

Source files
------------

// File: rtl/conv_relu_pool_engine.sv
// Streaming 3x3 convolution over a runtime-sized image with NUM_CH kernels,
// requantisation, optional ReLU and optional 2x2/stride-2 max pooling.
module conv_relu_pool_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int IMG_W_MAX  = 64,
  parameter int NUM_CH     = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [$clog2(IMG_W_MAX+1)-1:0]    cfg_width_i,
  input  logic [15:0]                       cfg_height_i,
  input  logic [4:0]                        cfg_shift_i,
  input  logic                              cfg_relu_en_i,
  input  logic                              cfg_pool_en_i,
  input  logic [NUM_CH*9*W_WIDTH-1:0]       weights_i,
  input  logic [DATA_WIDTH-1:0]             in_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [NUM_CH*OUT_WIDTH-1:0]       out_data_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              out_last_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);
  localparam int CW  = $clog2(IMG_W_MAX+1);
  localparam int AW  = $clog2(IMG_W_MAX);
  localparam int PAW = $clog2(IMG_W_MAX/2);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  function automatic logic signed [ACC_WIDTH-1:0] mul_px(input logic [DATA_WIDTH-1:0] px,
                                                         input logic signed [W_WIDTH-1:0] w);
    logic signed [ACC_WIDTH-1:0] pe, we;
    pe = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, px};
    we = {{(ACC_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w};
    return pe * we;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc,
                                                          input logic [4:0] sh,
                                                          input logic relu);
    logic signed [ACC_WIDTH-1:0] v;
    v = acc >>> sh;
    if (relu && v < 0) v = '0;
    if (v > SAT_MAX) v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[OUT_WIDTH-1:0];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] smax(input logic signed [OUT_WIDTH-1:0] a,
                                                       input logic signed [OUT_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                        state_q;
  logic [CW-1:0]                 w_q, col_q;
  logic [15:0]                   h_q, row_q;
  logic [4:0]                    shift_q;
  logic                          relu_q, pool_q;
  logic signed [W_WIDTH-1:0]     wts_q [NUM_CH][9];
  logic [DATA_WIDTH-1:0]         lb0_q [IMG_W_MAX];
  logic [DATA_WIDTH-1:0]         lb1_q [IMG_W_MAX];
  logic [DATA_WIDTH-1:0]         win_q [3][2];
  logic signed [OUT_WIDTH-1:0]   hmax_q [NUM_CH];
  logic signed [OUT_WIDTH-1:0]   rowbuf_q [IMG_W_MAX/2][NUM_CH];
  logic [NUM_CH*OUT_WIDTH-1:0]   out_data_q;
  logic                          out_valid_q, out_last_q, done_q, err_q;

  logic                          advance, accept, win_ok, emit, emit_last, last_pix, cfg_ok;
  logic [AW-1:0]                 ci;
  logic [PAW-1:0]                jh;
  logic [CW-1:0]                 j, w_pool_last;
  logic [15:0]                   i, h_pool_last;
  logic [DATA_WIDTH-1:0]         newcol [3];
  logic [DATA_WIDTH-1:0]         tap [9];
  logic signed [ACC_WIDTH-1:0]   acc [NUM_CH];
  logic signed [OUT_WIDTH-1:0]   y [NUM_CH];
  logic signed [OUT_WIDTH-1:0]   pm [NUM_CH];
  logic signed [OUT_WIDTH-1:0]   pool_v [NUM_CH];
  logic [NUM_CH*OUT_WIDTH-1:0]   emit_data_d;

  always_comb begin
    advance  = !out_valid_q || out_ready_i;
    accept   = (state_q == S_RUN) && advance && in_valid_i;
    cfg_ok   = (cfg_width_i >= CW'(3)) && (cfg_width_i <= CW'(IMG_W_MAX)) && (cfg_height_i >= 16'd3);
    ci       = col_q[AW-1:0];
    j        = col_q - CW'(2);
    i        = row_q - 16'd2;
    jh       = j[PAW:1];
    last_pix = accept && (row_q == h_q - 16'd1) && (col_q == w_q - CW'(1));
    win_ok   = accept && (row_q >= 16'd2) && (col_q >= CW'(2));
    // The window's right column comes straight from the line buffers and the incoming pixel.
    newcol[0] = lb1_q[ci];
    newcol[1] = lb0_q[ci];
    newcol[2] = in_data_i;
    for (int r = 0; r < 3; r++) begin
      tap[r*3+0] = win_q[r][0];
      tap[r*3+1] = win_q[r][1];
      tap[r*3+2] = newcol[r];
    end
    emit_data_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      acc[k] = '0;
      for (int t = 0; t < 9; t++) acc[k] = acc[k] + mul_px(tap[t], wts_q[k][t]);
      y[k]      = requant(acc[k], shift_q, relu_q);
      pm[k]     = smax(hmax_q[k], y[k]);
      pool_v[k] = smax(rowbuf_q[jh][k], pm[k]);
      emit_data_d[k*OUT_WIDTH +: OUT_WIDTH] = pool_q ? pool_v[k] : y[k];
    end
    w_pool_last = ((w_q - CW'(2)) & ~CW'(1)) - CW'(1);
    h_pool_last = ((h_q - 16'd2) & ~16'd1) - 16'd1;
    if (pool_q) begin
      emit      = win_ok && j[0] && i[0];
      emit_last = (j == w_pool_last) && (i == h_pool_last);
    end else begin
      emit      = win_ok;
      emit_last = last_pix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      pool_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        hmax_q[k] <= '0;
        for (int t = 0; t < 9; t++) wts_q[k][t] <= '0;
        for (int p = 0; p < IMG_W_MAX/2; p++) rowbuf_q[p][k] <= '0;
      end
      for (int c = 0; c < IMG_W_MAX; c++) begin
        lb0_q[c] <= '0;
        lb1_q[c] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          if (cfg_ok) begin
            w_q     <= cfg_width_i;
            h_q     <= cfg_height_i;
            shift_q <= cfg_shift_i;
            relu_q  <= cfg_relu_en_i;
            pool_q  <= cfg_pool_en_i;
            col_q   <= '0;
            row_q   <= '0;
            for (int k = 0; k < NUM_CH; k++)
              for (int t = 0; t < 9; t++)
                wts_q[k][t] <= weights_i[(k*9+t)*W_WIDTH +: W_WIDTH];
            state_q <= S_RUN;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_RUN: if (last_pix) state_q <= S_FLUSH;
        S_FLUSH: if (!out_valid_q || out_ready_i) begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        lb1_q[ci] <= lb0_q[ci];
        lb0_q[ci] <= in_data_i;
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= newcol[r];
        end
        if (col_q == w_q - CW'(1)) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      // Even conv column holds the left half of a pair; even conv row parks the pair max.
      if (win_ok && pool_q) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (!j[0]) hmax_q[k] <= y[k];
          else if (!i[0]) rowbuf_q[jh][k] <= pm[k];
        end
      end

      if (advance) begin
        out_valid_q <= emit;
        if (emit) begin
          out_data_q <= emit_data_d;
          out_last_q <= emit_last;
        end
      end
    end
  end

  assign in_ready_o  = (state_q == S_RUN) && advance;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule
